// File: rtl/calc_pkg.sv
// Shared widths, FSM encodings and LED bit positions for the calculator sequencer.
// Optional debounce is enabled by defining CALC_DEBOUNCE_EN (see calc_button).
package calc_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 4;

  // Legacy-compatible fixed encodings; State output exposes these directly.
  localparam logic [STATE_W-1:0] StIdle   = 3'd0;
  localparam logic [STATE_W-1:0] StWithA  = 3'd1;
  localparam logic [STATE_W-1:0] StWithB  = 3'd2;
  localparam logic [STATE_W-1:0] StExec   = 3'd3;
  localparam logic [STATE_W-1:0] StResult = 3'd4;

  localparam int unsigned LedZero  = 0;
  localparam int unsigned LedCarry = 1;
  localparam int unsigned LedOvf   = 2;
  localparam int unsigned LedValid = 3;

endpackage

// File: rtl/calc_sequencer_if.sv
// Board/ALU-facing signal bundle of the calculator sequencer.
// slave: the sequencer side; master: the board/ALU side driving switches and ALU flags.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic [OP_W+DATA_W-1:0] Switchs;
  logic                   Enter;
  logic                   Clear;
  logic [DATA_W-1:0]      alu_A;
  logic [DATA_W-1:0]      alu_B;
  logic [OP_W-1:0]        alu_Op;
  logic [DATA_W-1:0]      alu_Result;
  logic                   alu_Carry;
  logic                   alu_Zero;
  logic                   alu_Overflow;
  logic [DATA_W-1:0]      Result;
  logic [STATE_W-1:0]     State;
  logic [3:0]             Leds;
  logic                   Busy;

  modport slave (
    input  Switchs, Enter, Clear, alu_Result, alu_Carry, alu_Zero, alu_Overflow,
    output alu_A, alu_B, alu_Op, Result, State, Leds, Busy
  );

  modport master (
    output Switchs, Enter, Clear, alu_Result, alu_Carry, alu_Zero, alu_Overflow,
    input  alu_A, alu_B, alu_Op, Result, State, Leds, Busy
  );

endinterface

// File: rtl/calc_button.sv
// Push-button conditioner: 2-flop synchronizer, optional debounce filter
// (CALC_DEBOUNCE_EN), and a registered single-cycle rising-edge pulse.
module calc_button #(
  parameter int unsigned DEBOUNCE_CYCLES = 16  // must be >= 1 when debounce is enabled
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q;
  logic level;
  logic prev_q, armed_q, primed_q, pulse_q;
  logic armed_d, pulse_d;

  // Two-stage synchronizer for the asynchronous button.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] db_cnt_q, db_cnt_d;
  logic            filt_q, filt_d;

  // Filtered level follows the synchronized level only after it has differed
  // for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (db_cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // Arm only once a genuine low has been seen after the synchronizer has filled, so a
  // button held through reset release cannot fire.
  always_comb begin
    armed_d = armed_q | (primed_q & ~sync1_q & ~level);
    pulse_d = level & ~prev_q & armed_q;
  end

  // Edge-detect registers; the pulse is registered for a clean single-cycle output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q   <= 1'b0;
      armed_q  <= 1'b0;
      primed_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      prev_q   <= level;
      armed_q  <= armed_d;
      primed_q <= 1'b1;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: collects operand A, operand B and opcode from the switches on
// successive Enter presses, waits ALU_LATENCY cycles, then captures the ALU result/flags.
// Clear returns to IDLE from anywhere. Define CALC_DEBOUNCE_EN to debounce the buttons.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ALU_LATENCY     = 1   // 1..15
) (
  input  logic           clock,
  input  logic           Reset_n,
  calc_sequencer_if.slave bus_io
);

  localparam logic [CNT_W-1:0] LatCnt = CNT_W'(ALU_LATENCY);

  logic enter_p, clear_p;

  logic [STATE_W-1:0] state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [3:0]         leds_q, leds_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  calc_button #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_enter_btn (
    .clk_i   (clock),
    .rst_ni  (Reset_n),
    .btn_i   (bus_io.Enter),
    .pulse_o (enter_p)
  );

  calc_button #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_clear_btn (
    .clk_i   (clock),
    .rst_ni  (Reset_n),
    .btn_i   (bus_io.Clear),
    .pulse_o (clear_p)
  );

  // Next-state and datapath decode; clear overrides everything, including a same-cycle enter.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    leds_d   = leds_q;
    cnt_d    = cnt_q;
    if (clear_p) begin
      state_d  = StIdle;
      a_d      = '0;
      b_d      = '0;
      op_d     = '0;
      result_d = '0;
      leds_d   = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enter_p) begin
            a_d     = bus_io.Switchs[DATA_W-1:0];
            state_d = StWithA;
          end
        end
        StWithA: begin
          if (enter_p) begin
            b_d     = bus_io.Switchs[DATA_W-1:0];
            state_d = StWithB;
          end
        end
        StWithB, StResult: begin
          if (enter_p) begin
            op_d             = bus_io.Switchs[OP_W+DATA_W-1:DATA_W];
            cnt_d            = LatCnt;
            leds_d[LedValid] = 1'b0;
            state_d          = StExec;
          end
        end
        StExec: begin
          // Enter is dropped here. A zero count is treated like 1 so EXEC always ends.
          if (cnt_q <= CNT_W'(1)) begin
            result_d         = bus_io.alu_Result;
            leds_d[LedZero]  = bus_io.alu_Zero;
            leds_d[LedCarry] = bus_io.alu_Carry;
            leds_d[LedOvf]   = bus_io.alu_Overflow;
            leds_d[LedValid] = 1'b1;
            cnt_d            = '0;
            state_d          = StResult;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      leds_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      leds_q   <= leds_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus_io.alu_A  = a_q;
  assign bus_io.alu_B  = b_q;
  assign bus_io.alu_Op = op_q;
  assign bus_io.Result = result_q;
  assign bus_io.State  = state_q;
  assign bus_io.Leds   = leds_q;
  assign bus_io.Busy   = (state_q == StExec);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a small behavioural ALU (op 0 add, op 1 sub).
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int unsigned DebCycles = 16;
  localparam int unsigned Hold      = DebCycles + 10;

  logic clock;
  logic Reset_n;

  calc_sequencer_if bus ();

  calc_sequencer #(
    .DEBOUNCE_CYCLES (DebCycles),
    .ALU_LATENCY     (1)
  ) dut (
    .clock   (clock),
    .Reset_n (Reset_n),
    .bus_io  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU.
  logic [8:0] alu_sum;
  logic [7:0] alu_res;
  logic       alu_c, alu_v;
  always_comb begin
    alu_sum = 9'd0;
    alu_res = 8'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.alu_Op)
      4'd0: begin
        alu_sum = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
        alu_res = alu_sum[7:0];
        alu_c   = alu_sum[8];
        alu_v   = (bus.alu_A[7] == bus.alu_B[7]) && (alu_res[7] != bus.alu_A[7]);
      end
      4'd1: begin
        alu_res = bus.alu_A - bus.alu_B;
        alu_c   = bus.alu_A < bus.alu_B;
        alu_v   = (bus.alu_A[7] != bus.alu_B[7]) && (alu_res[7] != bus.alu_A[7]);
      end
      default: alu_res = bus.alu_A & bus.alu_B;
    endcase
  end
  assign bus.alu_Result   = alu_res;
  assign bus.alu_Carry    = alu_c;
  assign bus.alu_Overflow = alu_v;
  assign bus.alu_Zero     = (alu_res == 8'd0);

  // Free-running observation counters; tests compare deltas.
  int unsigned trans_total = 0;
  int unsigned busy_total  = 0;
  int unsigned withb_total = 0;
  int unsigned led3_exec   = 0;
  logic [2:0]  last_state  = 3'd0;
  always @(negedge clock) begin
    if (bus.State != last_state) trans_total <= trans_total + 1;
    last_state <= bus.State;
    if (bus.Busy) busy_total <= busy_total + 1;
    if (bus.Busy && bus.Leds[3]) led3_exec <= led3_exec + 1;
    if (bus.State == StWithB) withb_total <= withb_total + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press_enter(input logic [11:0] sw);
    @(negedge clock);
    bus.Switchs = sw;
    bus.Enter   = 1'b1;
    repeat (Hold) @(negedge clock);
    bus.Enter = 1'b0;
    repeat (Hold) @(negedge clock);
  endtask

  task automatic press_clear();
    @(negedge clock);
    bus.Clear = 1'b1;
    repeat (Hold) @(negedge clock);
    bus.Clear = 1'b0;
    repeat (Hold) @(negedge clock);
  endtask

  int unsigned snap;

  initial begin
    Reset_n     = 1'b0;
    bus.Switchs = 12'h000;
    bus.Enter   = 1'b0;
    bus.Clear   = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_state", 32'(bus.State), 32'(StIdle));
    check_eq("rst_leds", 32'(bus.Leds), 32'h0);
    check_eq("rst_busy", 32'(bus.Busy), 32'h0);
    Reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // 5-cycle Enter glitch; without debounce also checks the N+3 latency.
    bus.Enter = 1'b1;
    @(posedge clock);
    repeat (3) @(negedge clock);
`ifndef CALC_DEBOUNCE_EN
    check_eq("lat_n2", 32'(bus.State), 32'(StIdle));
`endif
    @(negedge clock);
`ifndef CALC_DEBOUNCE_EN
    check_eq("lat_n3", 32'(bus.State), 32'(StWithA));
`endif
    @(negedge clock);
    bus.Enter = 1'b0;
    repeat (30) @(negedge clock);
`ifdef CALC_DEBOUNCE_EN
    check_eq("glitch", 32'(bus.State), 32'(StIdle));
`else
    check_eq("glitch", 32'(bus.State), 32'(StWithA));
`endif
    press_clear();
    check_eq("clr_state", 32'(bus.State), 32'(StIdle));

    // 5 + 3 with op 0.
    press_enter(12'h005);
    check_eq("a_state", 32'(bus.State), 32'(StWithA));
    check_eq("a_val", 32'(bus.alu_A), 32'h05);
    press_enter(12'h003);
    check_eq("b_state", 32'(bus.State), 32'(StWithB));
    check_eq("b_val", 32'(bus.alu_B), 32'h03);
    press_enter(12'h000);
    check_eq("add_state", 32'(bus.State), 32'(StResult));
    check_eq("add_res", 32'(bus.Result), 32'h08);
    check_eq("add_leds", 32'(bus.Leds), 32'h8);
    check_eq("add_busy", 32'(bus.Busy), 32'h0);

    // 0x7F + 0x01 overflow, then re-execute from RESULT.
    press_clear();
    check_eq("clr_res", 32'(bus.Result), 32'h0);
    check_eq("clr_a", 32'(bus.alu_A), 32'h0);
    press_enter(12'h07F);
    press_enter(12'h001);
    press_enter(12'h000);
    check_eq("ovf_res", 32'(bus.Result), 32'h80);
    check_eq("ovf_leds", 32'(bus.Leds), 32'hC);
    snap = busy_total;
    press_enter(12'h000);
    check_eq("reexec_busy", busy_total - snap, 32'd1);
    check_eq("reexec_led3", led3_exec, 32'd0);
    check_eq("reexec_leds", 32'(bus.Leds), 32'hC);
    press_enter(12'h100);
    check_eq("sub_op", 32'(bus.alu_Op), 32'h1);
    check_eq("sub_res", 32'(bus.Result), 32'h7E);
    check_eq("sub_leds", 32'(bus.Leds), 32'h8);
    check_eq("sub_state", 32'(bus.State), 32'(StResult));

    // Clear and Enter together in WITH_A.
    press_clear();
    press_enter(12'h012);
    check_eq("ce_pre", 32'(bus.State), 32'(StWithA));
    snap = withb_total;
    @(negedge clock);
    bus.Switchs = 12'h034;
    bus.Enter   = 1'b1;
    bus.Clear   = 1'b1;
    repeat (Hold) @(negedge clock);
    bus.Enter = 1'b0;
    bus.Clear = 1'b0;
    repeat (Hold) @(negedge clock);
    check_eq("ce_state", 32'(bus.State), 32'(StIdle));
    check_eq("ce_a", 32'(bus.alu_A), 32'h0);
    check_eq("ce_nowithb", withb_total - snap, 32'd0);

    // Enter held 100 cycles in IDLE.
    @(negedge clock);
    snap        = trans_total;
    bus.Switchs = 12'h012;
    bus.Enter   = 1'b1;
    repeat (100) @(negedge clock);
    @(negedge clock);
    check_eq("hold_trans", trans_total - snap, 32'd1);
    check_eq("hold_state", 32'(bus.State), 32'(StWithA));
    bus.Enter = 1'b0;
    repeat (Hold) @(negedge clock);

    // Asynchronous reset in WITH_B, with Enter held through release.
    press_enter(12'h034);
    check_eq("wb_state", 32'(bus.State), 32'(StWithB));
    check_eq("wb_a", 32'(bus.alu_A), 32'h12);
    @(negedge clock);
    #2;
    bus.Enter = 1'b1;
    Reset_n   = 1'b0;
    #1;
    check_eq("arst_state", 32'(bus.State), 32'(StIdle));
    check_eq("arst_a", 32'(bus.alu_A), 32'h0);
    check_eq("arst_leds", 32'(bus.Leds), 32'h0);
    repeat (3) @(negedge clock);
    snap    = trans_total;
    Reset_n = 1'b1;
    repeat (Hold) @(negedge clock);
    check_eq("rel_state", 32'(bus.State), 32'(StIdle));
    check_eq("rel_trans", trans_total - snap, 32'd0);
    bus.Enter = 1'b0;
    repeat (Hold) @(negedge clock);

    // Buttons still work after reset released with Enter held.
    press_enter(12'h009);
    check_eq("post_state", 32'(bus.State), 32'(StWithA));
    check_eq("post_a", 32'(bus.alu_A), 32'h09);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
